// File: rtl/fft8_pkg.sv
// -----------------------------------------------------------------------------
// fft8_pkg
//
// Purpose:
//   Shared definitions for the 8-point radix-2 butterfly datapath. Holds the
//   default sample width and the sample type. The datapath uses plain modulo
//   2^WIDTH arithmetic, so this type carries no growth or guard bits.
//
// Contents:
//   FFT8_WIDTH    default bit width of every input/output sample
//   FFT8_NUM_PTS  number of samples per vector
//   sample_t      one sample at the default width
// -----------------------------------------------------------------------------
package fft8_pkg;

  localparam int FFT8_WIDTH   = 8;
  localparam int FFT8_NUM_PTS = 8;

  typedef logic [FFT8_WIDTH-1:0] sample_t;

endpackage : fft8_pkg

// File: rtl/fft8_bfly2.sv
// -----------------------------------------------------------------------------
// fft8_bfly2
//
// Purpose:
//   Combinational radix-2 butterfly pair. It produces the sum and the
//   difference of two samples. Both results are truncated to WIDTH bits, so
//   the arithmetic wraps around modulo 2^WIDTH in both unsigned and
//   two's-complement terms.
//
// Ports:
//   i_p     in   WIDTH  first operand
//   i_q     in   WIDTH  second operand
//   o_sum   out  WIDTH  i_p + i_q (mod 2^WIDTH)
//   o_diff  out  WIDTH  i_p - i_q (mod 2^WIDTH)
// -----------------------------------------------------------------------------
module fft8_bfly2
  import fft8_pkg::*;
#(
  parameter int WIDTH = FFT8_WIDTH
) (
  input  logic [WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_diff
);

  // Both operands and both results have the same width. The carry/borrow out
  // of the top bit is dropped, which gives the wrap-around behaviour the
  // datapath relies on.
  assign o_sum  = i_p + i_q;
  assign o_diff = i_p - i_q;

endmodule : fft8_bfly2

// File: rtl/fft8_butterfly.sv
// -----------------------------------------------------------------------------
// fft8_butterfly
//
// Purpose:
//   Two-level radix-2 butterfly network with 8 inputs. This is the
//   add/subtract core of an 8-point transform. The even inputs (X0,X2,X4,X6)
//   feed Y0,Y2,Y4,Y6. The odd inputs (X1,X3,X5,X7) feed Y1,Y3,Y5,Y7.
//
//   Level 1 is combinational:
//     a=X0+X4  b=X0-X4  c=X2+X6  d=X2-X6
//     e=X1+X5  f=X1-X5  g=X3+X7  h=X3-X7
//   Level 2 is combinational and feeds one register stage:
//     Y0=a+c  Y4=a-c  Y2=b+d  Y6=b-d
//     Y1=e+g  Y5=e-g  Y3=f-h  Y7=f+h
//   All values wrap modulo 2^WIDTH. The latency is exactly one clock. A new
//   vector can be accepted every cycle. There is no handshake.
//
// Ports:
//   phi1    in   1      clock; all state updates on the rising edge
//   reset   in   1      synchronous, active-high; clears Y0..Y7
//   X0..X7  in   WIDTH  input samples, sampled on every rising edge
//   Y0..Y7  out  WIDTH  registered butterfly results
// -----------------------------------------------------------------------------
module fft8_butterfly
  import fft8_pkg::*;
#(
  parameter int WIDTH = FFT8_WIDTH
) (
  input  logic             phi1,
  input  logic             reset,
  input  logic [WIDTH-1:0] X0,
  input  logic [WIDTH-1:0] X1,
  input  logic [WIDTH-1:0] X2,
  input  logic [WIDTH-1:0] X3,
  input  logic [WIDTH-1:0] X4,
  input  logic [WIDTH-1:0] X5,
  input  logic [WIDTH-1:0] X6,
  input  logic [WIDTH-1:0] X7,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic [WIDTH-1:0] Y4,
  output logic [WIDTH-1:0] Y5,
  output logic [WIDTH-1:0] Y6,
  output logic [WIDTH-1:0] Y7
);

  // Level-1 intermediates
  logic [WIDTH-1:0] w_a, w_b, w_c, w_d;
  logic [WIDTH-1:0] w_e, w_f, w_g, w_h;

  // Level-2 results, before the output register
  logic [WIDTH-1:0] w_y0, w_y1, w_y2, w_y3;
  logic [WIDTH-1:0] w_y4, w_y5, w_y6, w_y7;

  // Output register bank
  logic [WIDTH-1:0] r_y0, r_y1, r_y2, r_y3;
  logic [WIDTH-1:0] r_y4, r_y5, r_y6, r_y7;

  // ---------------------------------------------------------------------------
  // Level 1: each butterfly pairs input n with input n+4.
  // ---------------------------------------------------------------------------
  fft8_bfly2 #(.WIDTH(WIDTH)) u_l1_x0x4 (
    .i_p   (X0),
    .i_q   (X4),
    .o_sum (w_a),
    .o_diff(w_b)
  );

  fft8_bfly2 #(.WIDTH(WIDTH)) u_l1_x2x6 (
    .i_p   (X2),
    .i_q   (X6),
    .o_sum (w_c),
    .o_diff(w_d)
  );

  fft8_bfly2 #(.WIDTH(WIDTH)) u_l1_x1x5 (
    .i_p   (X1),
    .i_q   (X5),
    .o_sum (w_e),
    .o_diff(w_f)
  );

  fft8_bfly2 #(.WIDTH(WIDTH)) u_l1_x3x7 (
    .i_p   (X3),
    .i_q   (X7),
    .o_sum (w_g),
    .o_diff(w_h)
  );

  // ---------------------------------------------------------------------------
  // Level 2: the even half combines (a,c) and (b,d).
  // ---------------------------------------------------------------------------
  fft8_bfly2 #(.WIDTH(WIDTH)) u_l2_ac (
    .i_p   (w_a),
    .i_q   (w_c),
    .o_sum (w_y0),
    .o_diff(w_y4)
  );

  fft8_bfly2 #(.WIDTH(WIDTH)) u_l2_bd (
    .i_p   (w_b),
    .i_q   (w_d),
    .o_sum (w_y2),
    .o_diff(w_y6)
  );

  // ---------------------------------------------------------------------------
  // Level 2: the odd half combines (e,g) and (f,h).
  // For the (f,h) pair the roles are swapped relative to the even side:
  // the difference goes to Y3 and the sum goes to Y7.
  // ---------------------------------------------------------------------------
  fft8_bfly2 #(.WIDTH(WIDTH)) u_l2_eg (
    .i_p   (w_e),
    .i_q   (w_g),
    .o_sum (w_y1),
    .o_diff(w_y5)
  );

  fft8_bfly2 #(.WIDTH(WIDTH)) u_l2_fh (
    .i_p   (w_f),
    .i_q   (w_h),
    .o_sum (w_y7),
    .o_diff(w_y3)
  );

  // ---------------------------------------------------------------------------
  // Output register: every edge captures a new result. Reset takes priority
  // over incoming data. This register is the only path from X to Y.
  // ---------------------------------------------------------------------------
  always_ff @(posedge phi1) begin
    if (reset) begin
      r_y0 <= '0;
      r_y1 <= '0;
      r_y2 <= '0;
      r_y3 <= '0;
      r_y4 <= '0;
      r_y5 <= '0;
      r_y6 <= '0;
      r_y7 <= '0;
    end else begin
      r_y0 <= w_y0;
      r_y1 <= w_y1;
      r_y2 <= w_y2;
      r_y3 <= w_y3;
      r_y4 <= w_y4;
      r_y5 <= w_y5;
      r_y6 <= w_y6;
      r_y7 <= w_y7;
    end
  end

  assign Y0 = r_y0;
  assign Y1 = r_y1;
  assign Y2 = r_y2;
  assign Y3 = r_y3;
  assign Y4 = r_y4;
  assign Y5 = r_y5;
  assign Y6 = r_y6;
  assign Y7 = r_y7;

endmodule : fft8_butterfly

// File: tb/tb_fft8_butterfly.sv
// -----------------------------------------------------------------------------
// tb_fft8_butterfly
//
// Purpose:
//   Directed testbench for fft8_butterfly. Each scenario task drives its own
//   vectors and compares Y0..Y7 against hand-computed constants or against a
//   small reference model of the butterfly formulas.
// -----------------------------------------------------------------------------
module tb_fft8_butterfly;

  typedef logic [7:0][7:0] vec_t;

  logic       phi1;
  logic       reset;
  logic [7:0] X0, X1, X2, X3, X4, X5, X6, X7;
  logic [7:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;

  vec_t yObs;

  int checkCount;
  int passCount;

  fft8_butterfly #(.WIDTH(8)) dut (
    .phi1 (phi1),
    .reset(reset),
    .X0(X0), .X1(X1), .X2(X2), .X3(X3),
    .X4(X4), .X5(X5), .X6(X6), .X7(X7),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .Y4(Y4), .Y5(Y5), .Y6(Y6), .Y7(Y7)
  );

  // 10-time-unit clock period.
  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  // Gather the outputs so that index n corresponds to Yn.
  assign yObs = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

  // Reference model for the butterfly formulas. It computes every
  // intermediate at 8 bits, so all results wrap modulo 256.
  function automatic vec_t refModel(input vec_t x);
    logic [7:0] a, b, c, d, e, f, g, h;
    vec_t y;
    a = x[0] + x[4];
    b = x[0] - x[4];
    c = x[2] + x[6];
    d = x[2] - x[6];
    e = x[1] + x[5];
    f = x[1] - x[5];
    g = x[3] + x[7];
    h = x[3] - x[7];
    y[0] = a + c;
    y[4] = a - c;
    y[2] = b + d;
    y[6] = b - d;
    y[1] = e + g;
    y[5] = e - g;
    y[3] = f - h;
    y[7] = f + h;
    return y;
  endfunction

  // Drive all eight inputs from one vector. Index n drives Xn.
  task automatic setInputs(input vec_t v);
    X0 = v[0]; X1 = v[1]; X2 = v[2]; X3 = v[3];
    X4 = v[4]; X5 = v[5]; X6 = v[6]; X7 = v[7];
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic stepEdge();
    @(posedge phi1);
    #1;
  endtask

  // Hold reset for two edges with all inputs at FF. Y must read 00 after each edge.
  task automatic test_reset();
    vec_t allOnes;
    allOnes = {8{8'hFF}};
    reset = 1'b1;
    setInputs(allOnes);
    for (int cyc = 0; cyc < 2; cyc++) begin
      stepEdge();
      for (int i = 0; i < 8; i++) begin
        checkCount++;
        if (yObs[i] !== 8'h00)
          $display("[TB] FAIL reset cyc%0d Y%0d: got %h expected 00", cyc, i, yObs[i]);
        else
          passCount++;
      end
    end
    reset = 1'b0;
  endtask

  // Impulse on X0. The outputs must not move before the edge. After the
  // edge, the even outputs read 01 and the odd outputs read 00.
  task automatic test_impulse();
    vec_t v;
    vec_t expY;
    v       = '0;
    v[0]    = 8'h01;
    expY    = '0;
    expY[0] = 8'h01;
    expY[2] = 8'h01;
    expY[4] = 8'h01;
    expY[6] = 8'h01;
    setInputs(v);
    #2;
    for (int i = 0; i < 8; i++) begin
      checkCount++;
      if (yObs[i] !== 8'h00)
        $display("[TB] FAIL no_comb_path Y%0d: got %h expected 00", i, yObs[i]);
      else
        passCount++;
    end
    stepEdge();
    for (int i = 0; i < 8; i++) begin
      checkCount++;
      if (yObs[i] !== expY[i])
        $display("[TB] FAIL impulse Y%0d: got %h expected %h", i, yObs[i], expY[i]);
      else
        passCount++;
    end
  endtask

  // Ramp input 01..08. The expected values are hand-computed constants.
  task automatic test_ramp();
    vec_t v;
    vec_t expY;
    v    = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    expY = {8'hF8, 8'h00, 8'hFC, 8'hFC, 8'h00, 8'hF8, 8'h14, 8'h10};
    setInputs(v);
    stepEdge();
    for (int i = 0; i < 8; i++) begin
      checkCount++;
      if (yObs[i] !== expY[i])
        $display("[TB] FAIL ramp Y%0d: got %h expected %h", i, yObs[i], expY[i]);
      else
        passCount++;
    end
  endtask

  // All inputs FF exercise the wrap-around: Y0=Y1=FC and every other output is 00.
  task automatic test_wrap();
    vec_t v;
    vec_t expY;
    v       = {8{8'hFF}};
    expY    = '0;
    expY[0] = 8'hFC;
    expY[1] = 8'hFC;
    setInputs(v);
    stepEdge();
    for (int i = 0; i < 8; i++) begin
      checkCount++;
      if (yObs[i] !== expY[i])
        $display("[TB] FAIL wrap Y%0d: got %h expected %h", i, yObs[i], expY[i]);
      else
        passCount++;
    end
  endtask

  // Eight random vectors, one per cycle. Each result is checked one edge
  // after its vector was applied.
  task automatic test_back_to_back();
    vec_t v;
    vec_t expY;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) v[i] = 8'($urandom_range(0, 255));
      expY = refModel(v);
      setInputs(v);
      stepEdge();
      for (int i = 0; i < 8; i++) begin
        checkCount++;
        if (yObs[i] !== expY[i])
          $display("[TB] FAIL b2b vec%0d Y%0d: got %h expected %h", k, i, yObs[i], expY[i]);
        else
          passCount++;
      end
    end
  endtask

  // Assert reset for one edge between two vectors. That cycle reads 00. The
  // second vector's result appears one edge after reset drops.
  task automatic test_reset_midstream();
    vec_t vA;
    vec_t vB;
    vec_t expA;
    vec_t expB;
    vA   = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    vB   = {8'h9C, 8'h03, 8'hE1, 8'h40, 8'h7F, 8'h80, 8'h12, 8'hA5};
    expA = refModel(vA);
    expB = refModel(vB);
    setInputs(vA);
    stepEdge();
    for (int i = 0; i < 8; i++) begin
      checkCount++;
      if (yObs[i] !== expA[i])
        $display("[TB] FAIL midrst_pre Y%0d: got %h expected %h", i, yObs[i], expA[i]);
      else
        passCount++;
    end
    reset = 1'b1;
    setInputs(vB);
    stepEdge();
    for (int i = 0; i < 8; i++) begin
      checkCount++;
      if (yObs[i] !== 8'h00)
        $display("[TB] FAIL midrst_zero Y%0d: got %h expected 00", i, yObs[i]);
      else
        passCount++;
    end
    reset = 1'b0;
    stepEdge();
    for (int i = 0; i < 8; i++) begin
      checkCount++;
      if (yObs[i] !== expB[i])
        $display("[TB] FAIL midrst_resume Y%0d: got %h expected %h", i, yObs[i], expB[i]);
      else
        passCount++;
    end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    checkCount = 0;
    passCount  = 0;
    reset      = 1'b1;
    setInputs({8{8'hFF}});
    test_reset();
    test_impulse();
    test_ramp();
    test_wrap();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_fft8_butterfly
